// File: rtl/lane_game_engine.sv
// Lane-crossing game engine: frog position, per-lane cars, lives/score state machine
// and registered tile-hit flags for a tile-based video renderer.
module lane_game_engine #(
    parameter int N_LANES     = 4,
    parameter int GAME_WIDTH  = 20,
    parameter int GAME_HEIGHT = 15,
    parameter int BASE_PERIOD = 8,
    parameter int LIVES       = 3,
    parameter int SCORE_LIMIT = 99,
    parameter int HIT_FRAMES  = 30
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst,
    input  logic                 i_Game_Start,
    input  logic                 i_Frame_Tick,
    input  logic                 i_Up_Mvt,
    input  logic                 i_Down_Mvt,
    input  logic                 i_Left_Mvt,
    input  logic                 i_Right_Mvt,
    input  logic [4:0]           i_Col_Count_Div,
    input  logic [4:0]           i_Row_Count_Div,
    output logic [4:0]           o_Frog_X,
    output logic [4:0]           o_Frog_Y,
    output logic [5*N_LANES-1:0] o_Car_X,
    output logic [6:0]           o_Score,
    output logic [1:0]           o_Lives,
    output logic [2:0]           o_State,
    output logic                 o_Game_Active,
    output logic                 o_Draw_Frog,
    output logic                 o_Draw_Car
);
    localparam int CNT_W = $clog2(BASE_PERIOD + N_LANES) + 1;
    localparam int HIT_W = $clog2(HIT_FRAMES + 1) + 1;
    localparam logic [4:0] START_X = 5'(GAME_WIDTH / 2);
    localparam logic [4:0] START_Y = 5'(GAME_HEIGHT - 1);
    localparam logic [4:0] MAX_X   = 5'(GAME_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'b000,
        S_RUNNING   = 3'b001,
        S_HIT       = 3'b010,
        S_WIN       = 3'b011,
        S_GAME_OVER = 3'b100
    } state_t;

    state_t           state;
    logic [4:0]       frog_x, frog_y;
    logic [4:0]       car_x     [N_LANES];
    logic [CNT_W-1:0] frame_cnt [N_LANES];
    logic [HIT_W-1:0] hit_cnt;
    logic [6:0]       score;
    logic [1:0]       lives;
    logic             draw_frog, draw_car;
    logic             collision, car_tile, active, restart;

    function automatic logic [4:0] lane_row(input int k);
        return 5'(GAME_HEIGHT - 2 - 2 * k);
    endfunction

    // Even lanes drift right, odd lanes drift left, both wrap around the board.
    function automatic logic [4:0] car_step(input logic [4:0] x, input int k);
        if (k % 2 == 0) return (x == MAX_X) ? 5'd0 : x + 5'd1;
        return (x == 5'd0) ? MAX_X : x - 5'd1;
    endfunction

    function automatic logic [4:0] sat_dec(input logic [4:0] v);
        return (v == 5'd0) ? 5'd0 : v - 5'd1;
    endfunction

    function automatic logic [4:0] sat_inc(input logic [4:0] v, input logic [4:0] lim);
        return (v >= lim) ? lim : v + 5'd1;
    endfunction

    assign active  = (state == S_RUNNING) || (state == S_HIT);
    assign restart = i_Game_Start && !active && (state != S_RUNNING);

    always_comb begin
        collision = 1'b0;
        car_tile  = 1'b0;
        for (int k = 0; k < N_LANES; k++) begin
            if (frog_y == lane_row(k) && frog_x == car_x[k]) collision = 1'b1;
            if (i_Row_Count_Div == lane_row(k) && i_Col_Count_Div == car_x[k]) car_tile = 1'b1;
        end
    end

    // Lane cars and their frame counters.
    always_ff @(posedge i_Clk) begin
        for (int k = 0; k < N_LANES; k++) begin
            if (i_Rst || restart) begin
                car_x[k]     <= 5'd0;
                frame_cnt[k] <= '0;
            end else if (active && i_Frame_Tick) begin
                if (frame_cnt[k] == CNT_W'(BASE_PERIOD + k - 1)) begin
                    frame_cnt[k] <= '0;
                    car_x[k]     <= car_step(car_x[k], k);
                end else begin
                    frame_cnt[k] <= frame_cnt[k] + 1'b1;
                end
            end
        end
    end

    // Game state machine: collisions outrank the goal row, which outranks moves.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state   <= S_IDLE;
            score   <= 7'd0;
            lives   <= 2'(LIVES);
            frog_x  <= START_X;
            frog_y  <= START_Y;
            hit_cnt <= '0;
        end else begin
            case (state)
                S_RUNNING: begin
                    if (collision) begin
                        lives   <= lives - 2'd1;
                        hit_cnt <= '0;
                        state   <= (lives == 2'd1) ? S_GAME_OVER : S_HIT;
                    end else if (frog_y == 5'd0) begin
                        score  <= score + 7'd1;
                        frog_x <= START_X;
                        frog_y <= START_Y;
                        if (score + 7'd1 == 7'(SCORE_LIMIT)) state <= S_WIN;
                    end else if (i_Up_Mvt) begin
                        frog_y <= sat_dec(frog_y);
                    end else if (i_Down_Mvt) begin
                        frog_y <= sat_inc(frog_y, START_Y);
                    end else if (i_Left_Mvt) begin
                        frog_x <= sat_dec(frog_x);
                    end else if (i_Right_Mvt) begin
                        frog_x <= sat_inc(frog_x, MAX_X);
                    end
                end
                S_HIT: begin
                    if (i_Frame_Tick) begin
                        if (hit_cnt == HIT_W'(HIT_FRAMES - 1)) begin
                            hit_cnt <= '0;
                            frog_x  <= START_X;
                            frog_y  <= START_Y;
                            state   <= S_RUNNING;
                        end else begin
                            hit_cnt <= hit_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    if (i_Game_Start) begin
                        state   <= S_RUNNING;
                        score   <= 7'd0;
                        lives   <= 2'(LIVES);
                        frog_x  <= START_X;
                        frog_y  <= START_Y;
                        hit_cnt <= '0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            draw_frog <= 1'b0;
            draw_car  <= 1'b0;
        end else begin
            draw_frog <= (state != S_IDLE) && (i_Col_Count_Div == frog_x) && (i_Row_Count_Div == frog_y);
            draw_car  <= (state != S_IDLE) && car_tile;
        end
    end

    for (genvar g = 0; g < N_LANES; g++) begin : g_car_out
        assign o_Car_X[5*g +: 5] = car_x[g];
    end

    assign o_Frog_X      = frog_x;
    assign o_Frog_Y      = frog_y;
    assign o_Score       = score;
    assign o_Lives       = lives;
    assign o_State       = state;
    assign o_Game_Active = active;
    assign o_Draw_Frog   = draw_frog;
    assign o_Draw_Car    = draw_car;
endmodule
